// File: rtl/axi4_id_remapper.sv
// rtl/axi4_id_remapper.sv - AXI4 ID compressor with per-slot outstanding counts for read and write tables
// A wide master ID is bound to a narrow slot index until its final response retires the slot.

module axi4_id_remapper_table #(
   parameter int IN_ID_W  = 8,
   parameter int OUT_ID_W = 2,
   parameter int MAX_OUT  = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   input  logic                req_ready,
   input  logic [IN_ID_W-1:0]  req_id,
   output logic                req_stall,
   output logic [OUT_ID_W-1:0] req_slot,
   input  logic                rsp_valid,
   input  logic                rsp_ready,
   input  logic                rsp_last,
   input  logic [OUT_ID_W-1:0] rsp_slot,
   output logic [IN_ID_W-1:0]  rsp_id,
   output logic                rsp_err
);
   localparam int N     = 1 << OUT_ID_W;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [N-1:0]        vld;
   logic [IN_ID_W-1:0]  tid [N];
   logic [CNT_W-1:0]    cnt [N];

   logic                hit, free_found;
   logic [OUT_ID_W-1:0] hit_idx, free_idx;
   logic                req_fire, rsp_ok, rsp_dec;

   // Selection only looks at registered state, so a slot freed this cycle waits a cycle.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vld[i] && tid[i] == req_id) begin
            hit     = 1'b1;
            hit_idx = OUT_ID_W'(i);
         end
         if (!vld[i]) begin
            free_found = 1'b1;
            free_idx   = OUT_ID_W'(i);
         end
      end
   end

   assign req_slot  = hit ? hit_idx : free_idx;
   assign req_stall = hit ? (cnt[hit_idx] == CNT_W'(MAX_OUT)) : !free_found;
   assign req_fire  = req_valid && req_ready && !req_stall;

   assign rsp_ok  = vld[rsp_slot];
   assign rsp_id  = rsp_ok ? tid[rsp_slot] : '0;
   assign rsp_err = rsp_valid && rsp_ready && !rsp_ok;
   assign rsp_dec = rsp_valid && rsp_ready && rsp_last && rsp_ok;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld <= '0;
         for (int i = 0; i < N; i++) begin
            tid[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            // Simultaneous request and final response on one slot cancel out.
            if (req_fire && req_slot == OUT_ID_W'(i) &&
                !(rsp_dec && rsp_slot == OUT_ID_W'(i))) begin
               if (!vld[i]) begin
                  vld[i] <= 1'b1;
                  tid[i] <= req_id;
                  cnt[i] <= CNT_W'(1);
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else if (rsp_dec && rsp_slot == OUT_ID_W'(i) &&
                         !(req_fire && req_slot == OUT_ID_W'(i))) begin
               cnt[i] <= cnt[i] - CNT_W'(1);
               if (cnt[i] == CNT_W'(1))
                  vld[i] <= 1'b0;
            end
         end
      end
   end
endmodule

module axi4_id_remapper #(
   parameter int IN_ID_W  = 8,
   parameter int OUT_ID_W = 2,
   parameter int MAX_OUT  = 4,
   parameter int ADDR_W   = 31,
   parameter int DATA_W   = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  auto_in_awvalid,
   output logic                  auto_in_awready,
   input  logic [IN_ID_W-1:0]    auto_in_awid,
   input  logic [ADDR_W-1:0]     auto_in_awaddr,
   input  logic [7:0]            auto_in_awlen,
   input  logic [2:0]            auto_in_awsize,
   input  logic [1:0]            auto_in_awburst,
   input  logic                  auto_in_awlock,
   input  logic [3:0]            auto_in_awcache,
   input  logic [2:0]            auto_in_awprot,
   input  logic [3:0]            auto_in_awqos,
   input  logic                  auto_in_wvalid,
   output logic                  auto_in_wready,
   input  logic [DATA_W-1:0]     auto_in_wdata,
   input  logic [DATA_W/8-1:0]   auto_in_wstrb,
   input  logic                  auto_in_wlast,
   output logic                  auto_in_bvalid,
   input  logic                  auto_in_bready,
   output logic [IN_ID_W-1:0]    auto_in_bid,
   input  logic                  auto_in_arvalid,
   output logic                  auto_in_arready,
   input  logic [IN_ID_W-1:0]    auto_in_arid,
   input  logic [ADDR_W-1:0]     auto_in_araddr,
   input  logic [7:0]            auto_in_arlen,
   input  logic [2:0]            auto_in_arsize,
   input  logic [1:0]            auto_in_arburst,
   input  logic                  auto_in_arlock,
   input  logic [3:0]            auto_in_arcache,
   input  logic [2:0]            auto_in_arprot,
   input  logic [3:0]            auto_in_arqos,
   output logic                  auto_in_rvalid,
   input  logic                  auto_in_rready,
   output logic [IN_ID_W-1:0]    auto_in_rid,
   output logic [DATA_W-1:0]     auto_in_rdata,
   output logic                  auto_in_rlast,
   output logic                  auto_out_awvalid,
   input  logic                  auto_out_awready,
   output logic [OUT_ID_W-1:0]   auto_out_awid,
   output logic [ADDR_W-1:0]     auto_out_awaddr,
   output logic [7:0]            auto_out_awlen,
   output logic [2:0]            auto_out_awsize,
   output logic [1:0]            auto_out_awburst,
   output logic                  auto_out_awlock,
   output logic [3:0]            auto_out_awcache,
   output logic [2:0]            auto_out_awprot,
   output logic [3:0]            auto_out_awqos,
   output logic                  auto_out_wvalid,
   input  logic                  auto_out_wready,
   output logic [DATA_W-1:0]     auto_out_wdata,
   output logic [DATA_W/8-1:0]   auto_out_wstrb,
   output logic                  auto_out_wlast,
   input  logic                  auto_out_bvalid,
   output logic                  auto_out_bready,
   input  logic [OUT_ID_W-1:0]   auto_out_bid,
   output logic                  auto_out_arvalid,
   input  logic                  auto_out_arready,
   output logic [OUT_ID_W-1:0]   auto_out_arid,
   output logic [ADDR_W-1:0]     auto_out_araddr,
   output logic [7:0]            auto_out_arlen,
   output logic [2:0]            auto_out_arsize,
   output logic [1:0]            auto_out_arburst,
   output logic                  auto_out_arlock,
   output logic [3:0]            auto_out_arcache,
   output logic [2:0]            auto_out_arprot,
   output logic [3:0]            auto_out_arqos,
   input  logic                  auto_out_rvalid,
   output logic                  auto_out_rready,
   input  logic [OUT_ID_W-1:0]   auto_out_rid,
   input  logic [DATA_W-1:0]     auto_out_rdata,
   input  logic                  auto_out_rlast,
   output logic                  id_err
);
   logic aw_stall, ar_stall, b_err, r_err;

   axi4_id_remapper_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_wr_tbl (
      .clock(clock), .reset(reset),
      .req_valid(auto_in_awvalid), .req_ready(auto_out_awready), .req_id(auto_in_awid),
      .req_stall(aw_stall), .req_slot(auto_out_awid),
      .rsp_valid(auto_out_bvalid), .rsp_ready(auto_out_bready), .rsp_last(1'b1),
      .rsp_slot(auto_out_bid), .rsp_id(auto_in_bid), .rsp_err(b_err)
   );

   axi4_id_remapper_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_rd_tbl (
      .clock(clock), .reset(reset),
      .req_valid(auto_in_arvalid), .req_ready(auto_out_arready), .req_id(auto_in_arid),
      .req_stall(ar_stall), .req_slot(auto_out_arid),
      .rsp_valid(auto_out_rvalid), .rsp_ready(auto_out_rready), .rsp_last(auto_out_rlast),
      .rsp_slot(auto_out_rid), .rsp_id(auto_in_rid), .rsp_err(r_err)
   );

   // Handshake signals are forced low while reset is held.
   assign auto_out_awvalid = reset && auto_in_awvalid && !aw_stall;
   assign auto_in_awready  = reset && auto_out_awready && !aw_stall;
   assign auto_out_arvalid = reset && auto_in_arvalid && !ar_stall;
   assign auto_in_arready  = reset && auto_out_arready && !ar_stall;
   assign auto_out_wvalid  = reset && auto_in_wvalid;
   assign auto_in_wready   = reset && auto_out_wready;
   assign auto_in_bvalid   = reset && auto_out_bvalid;
   assign auto_out_bready  = reset && auto_in_bready;
   assign auto_in_rvalid   = reset && auto_out_rvalid;
   assign auto_out_rready  = reset && auto_in_rready;

   assign auto_out_awaddr  = auto_in_awaddr;
   assign auto_out_awlen   = auto_in_awlen;
   assign auto_out_awsize  = auto_in_awsize;
   assign auto_out_awburst = auto_in_awburst;
   assign auto_out_awlock  = auto_in_awlock;
   assign auto_out_awcache = auto_in_awcache;
   assign auto_out_awprot  = auto_in_awprot;
   assign auto_out_awqos   = auto_in_awqos;
   assign auto_out_araddr  = auto_in_araddr;
   assign auto_out_arlen   = auto_in_arlen;
   assign auto_out_arsize  = auto_in_arsize;
   assign auto_out_arburst = auto_in_arburst;
   assign auto_out_arlock  = auto_in_arlock;
   assign auto_out_arcache = auto_in_arcache;
   assign auto_out_arprot  = auto_in_arprot;
   assign auto_out_arqos   = auto_in_arqos;
   assign auto_out_wdata   = auto_in_wdata;
   assign auto_out_wstrb   = auto_in_wstrb;
   assign auto_out_wlast   = auto_in_wlast;
   assign auto_in_rdata    = auto_out_rdata;
   assign auto_in_rlast    = auto_out_rlast;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         id_err <= 1'b0;
      else if (b_err || r_err)
         id_err <= 1'b1;
   end
endmodule
